mem_io_sequencer: RTL and testbench

- Multi-cycle successor to the single-cycle MEM-stage control decode.
- Accepts one memory or I/O micro-op (LD, ST, IN, OUT) from the MEM stage and runs the bus cycle through an FSM.
- Inserts programmable and external wait states, stalls the pipeline, and returns read data.
- For IN, it returns corrected S/Z/H/P/N flags; for unflushed stores, it raises the paging-detect pulse.

---
 rtl/mem_io_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_mem_io_sequencer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mem_io_sequencer.sv
// Multi-cycle MEM-stage bus sequencer for LD/ST/IN/OUT micro-ops.
// Runs one bus cycle at a time with fixed and external wait states and a wait timeout.
module mem_io_sequencer #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 16,
    parameter int MEM_WAIT = 0,
    parameter int IO_WAIT  = 1,
    parameter int TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        op_kind,
    input  logic              op_valid,
    input  logic              flush_in,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [7:0]        flag_in,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_wait,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              mreq,
    output logic              iorq,
    output logic              rd,
    output logic              wr,
    output logic              stall,
    output logic              done,
    output logic              result_sel,
    output logic [DATA_W-1:0] rdata_out,
    output logic [7:0]        flag_out,
    output logic              flag_we,
    output logic              page_write,
    output logic              bus_err
);

    localparam logic [2:0] KIND_LD  = 3'd1;
    localparam logic [2:0] KIND_ST  = 3'd2;
    localparam logic [2:0] KIND_IN  = 3'd3;
    localparam logic [2:0] KIND_OUT = 3'd4;
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_COMPLETE = 2'd2} state_t;

    // Flag byte S Z 5 H 3 P/V N C: arithmetic bits recomputed, bits 5/3/0 pass through.
    function automatic logic [7:0] in_flags(input logic [DATA_W-1:0] d, input logic [7:0] f);
        in_flags = {d[DATA_W-1], (d == '0), f[5], 1'b0, f[3], ~^d, 1'b0, f[0]};
    endfunction

    state_t              state_q, state_d;
    logic [2:0]          kind_q, kind_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [7:0]          flag_q, flag_d;
    logic [2:0]          wait_q, wait_d;
    logic [7:0]          tmo_q, tmo_d;
    logic                cancel_q, cancel_d;
    logic                done_q, done_d;
    logic                rsel_q, rsel_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [7:0]          fout_q, fout_d;
    logic                fwe_q, fwe_d;
    logic                pw_q, pw_d;
    logic                err_q, err_d;
    logic                op_ok_s, accept_s, is_read_s, is_mem_s, cancel_now_s;

    always_comb begin
        op_ok_s      = op_valid && !flush_in && (op_kind >= KIND_LD) && (op_kind <= KIND_OUT);
        accept_s     = op_ok_s && (state_q != S_ACCESS);
        is_read_s    = (kind_q == KIND_LD) || (kind_q == KIND_IN);
        is_mem_s     = (op_kind == KIND_LD) || (op_kind == KIND_ST);
        cancel_now_s = cancel_q || flush_in;

        state_d  = state_q;
        kind_d   = kind_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        flag_d   = flag_q;
        wait_d   = wait_q;
        tmo_d    = tmo_q;
        cancel_d = cancel_q;
        done_d   = 1'b0;
        rsel_d   = rsel_q;
        rdata_d  = rdata_q;
        fout_d   = fout_q;
        fwe_d    = 1'b0;
        pw_d     = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            S_IDLE, S_COMPLETE: begin
                if (accept_s) begin
                    state_d  = S_ACCESS;
                    kind_d   = op_kind;
                    addr_d   = addr;
                    wdata_d  = wdata;
                    flag_d   = flag_in;
                    wait_d   = is_mem_s ? 3'(MEM_WAIT) : 3'(IO_WAIT);
                    tmo_d    = 8'd0;
                    cancel_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCESS: begin
                // A flush only cancels the reporting; the bus cycle always runs to the end.
                cancel_d = cancel_now_s;
                if (wait_q != 3'd0) begin
                    wait_d = wait_q - 3'd1;
                end else if (!bus_wait) begin
                    state_d = S_COMPLETE;
                    done_d  = !cancel_now_s;
                    rsel_d  = is_read_s;
                    fout_d  = (kind_q == KIND_IN) ? in_flags(bus_rdata, flag_q) : flag_q;
                    fwe_d   = (kind_q == KIND_IN) && !cancel_now_s;
                    pw_d    = (kind_q == KIND_ST) && !cancel_now_s;
                    if (is_read_s && !cancel_now_s) begin
                        rdata_d = bus_rdata;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else if (tmo_q >= TMO_LAST) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, latched op and registered result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            kind_q   <= 3'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            flag_q   <= 8'd0;
            wait_q   <= 3'd0;
            tmo_q    <= 8'd0;
            cancel_q <= 1'b0;
            done_q   <= 1'b0;
            rsel_q   <= 1'b0;
            rdata_q  <= '0;
            fout_q   <= 8'd0;
            fwe_q    <= 1'b0;
            pw_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            flag_q   <= flag_d;
            wait_q   <= wait_d;
            tmo_q    <= tmo_d;
            cancel_q <= cancel_d;
            done_q   <= done_d;
            rsel_q   <= rsel_d;
            rdata_q  <= rdata_d;
            fout_q   <= fout_d;
            fwe_q    <= fwe_d;
            pw_q     <= pw_d;
            err_q    <= err_d;
        end
    end

    // Strobes decode from registered state and kind only.
    always_comb begin
        mreq  = (state_q == S_ACCESS) && ((kind_q == KIND_LD) || (kind_q == KIND_ST));
        iorq  = (state_q == S_ACCESS) && ((kind_q == KIND_IN) || (kind_q == KIND_OUT));
        rd    = (state_q == S_ACCESS) && is_read_s;
        wr    = (state_q == S_ACCESS) && ((kind_q == KIND_ST) || (kind_q == KIND_OUT));
        stall = (state_q == S_ACCESS) || accept_s;
    end

    assign bus_addr   = addr_q;
    assign bus_wdata  = wdata_q;
    assign done       = done_q;
    assign result_sel = rsel_q;
    assign rdata_out  = rdata_q;
    assign flag_out   = fout_q;
    assign flag_we    = fwe_q;
    assign page_write = pw_q;
    assign bus_err    = err_q;

endmodule

// File: tb/tb_mem_io_sequencer.sv
// Directed bench for mem_io_sequencer: inputs driven and outputs sampled on the falling edge.
module tb_mem_io_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  op_kind;
    logic        op_valid;
    logic        flush_in;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  flag_in;
    logic [7:0]  bus_rdata;
    logic        bus_wait;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        mreq, iorq, rd, wr, stall, done, result_sel;
    logic [7:0]  rdata_out;
    logic [7:0]  flag_out;
    logic        flag_we, page_write, bus_err;

    int checks_q   = 0;
    int failures_q = 0;
    int cnt;
    int seen;

    mem_io_sequencer #(.DATA_W(8), .ADDR_W(16), .MEM_WAIT(0), .IO_WAIT(1), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .op_kind(op_kind), .op_valid(op_valid), .flush_in(flush_in),
        .addr(addr), .wdata(wdata), .flag_in(flag_in), .bus_rdata(bus_rdata), .bus_wait(bus_wait),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .mreq(mreq), .iorq(iorq), .rd(rd), .wr(wr),
        .stall(stall), .done(done), .result_sel(result_sel), .rdata_out(rdata_out),
        .flag_out(flag_out), .flag_we(flag_we), .page_write(page_write), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_q = checks_q + 1;
        if (got !== exp) begin
            failures_q = failures_q + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic present(input logic [2:0] k, input logic [15:0] a, input logic [7:0] d);
        op_kind  = k;
        addr     = a;
        wdata    = d;
        op_valid = 1'b1;
    endtask

    initial begin
        reset = 1'b1; op_kind = 3'd0; op_valid = 1'b0; flush_in = 1'b0; addr = 16'h0;
        wdata = 8'h0; flag_in = 8'h0; bus_rdata = 8'h0; bus_wait = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_strobes", {28'd0, mreq, iorq, rd, wr}, 32'd0);
        check_eq("rst_ctrl", {27'd0, stall, done, flag_we, page_write, bus_err}, 32'd0);
        check_eq("rst_data", {bus_addr, bus_wdata, rdata_out}, 32'd0);
        check_eq("rst_flags", {23'd0, result_sel, flag_out}, 32'd0);
        reset = 1'b0;

        // Reset mid-ACCESS of a LD discards it.
        @(negedge clk); present(3'd1, 16'h0040, 8'h00); bus_rdata = 8'h77;
        @(negedge clk); op_valid = 1'b0;
        check_eq("mid_ld_mreq", {30'd0, mreq, rd}, 32'd3);
        reset = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_strobes", {28'd0, mreq, iorq, rd, wr}, 32'd0);
        check_eq("mid_rst_done", {31'd0, done}, 32'd0);
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_nodone", {31'd0, done}, 32'd0);
        check_eq("mid_rst_rdata", {24'd0, rdata_out}, 32'd0);

        // LD, no waits: done two cycles after accept.
        present(3'd1, 16'h1234, 8'h00); bus_rdata = 8'h5A; flag_in = 8'h81;
        #1 check_eq("ld_accept_stall", {31'd0, stall}, 32'd1);
        @(negedge clk); op_valid = 1'b0;
        check_eq("ld_strobes", {28'd0, mreq, iorq, rd, wr}, 32'b1010);
        check_eq("ld_addr", {16'd0, bus_addr}, 32'h1234);
        check_eq("ld_nodone_c1", {30'd0, done, stall}, 32'd1);
        @(negedge clk);
        check_eq("ld_done", {30'd0, done, result_sel}, 32'd3);
        check_eq("ld_rdata", {24'd0, rdata_out}, 32'h5A);
        check_eq("ld_flags", {22'd0, flag_we, page_write, flag_out}, 32'h081);
        check_eq("ld_idle", {27'd0, mreq, iorq, rd, wr, stall}, 32'd0);
        @(negedge clk);
        check_eq("ld_done_pulse", {31'd0, done}, 32'd0);

        // Op presented with flush in the same cycle is dropped.
        present(3'd1, 16'h5555, 8'h00); flush_in = 1'b1;
        #1 check_eq("flush_drop_stall", {31'd0, stall}, 32'd0);
        @(negedge clk); op_valid = 1'b0; flush_in = 1'b0;
        check_eq("flush_drop_bus", {28'd0, mreq, iorq, rd, wr}, 32'd0);
        check_eq("flush_drop_addr", {16'd0, bus_addr}, 32'h1234);

        // IN, one fixed wait plus two bus_wait cycles: data 0 gives S0 Z1 H0 P1 N0.
        present(3'd3, 16'h0042, 8'h00); bus_rdata = 8'h00; flag_in = 8'hFF;
        cnt = 0; seen = 0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk); op_valid = 1'b0;
            bus_wait = (i <= 3);
            if (iorq && rd && !mreq && !wr) cnt = cnt + 1;
            if (done) seen = i;
        end
        bus_wait = 1'b0;
        check_eq("in_strobe_cycles", cnt, 32'd4);
        check_eq("in_done_cycle", seen, 32'd5);
        check_eq("in_flags", {24'd0, flag_out}, 32'h6D);
        check_eq("in_we_sel", {29'd0, flag_we, result_sel, page_write}, 32'b110);
        check_eq("in_rdata", {24'd0, rdata_out}, 32'h00);

        // ST flushed during ACCESS: bus cycle completes, no done/page_write.
        @(negedge clk); present(3'd2, 16'h8000, 8'h3C); flag_in = 8'h42;
        @(negedge clk); op_valid = 1'b0; flush_in = 1'b1;
        check_eq("stf_strobes", {28'd0, mreq, iorq, rd, wr}, 32'b1001);
        check_eq("stf_wdata", {8'd0, bus_addr, bus_wdata}, 32'h80003C);
        @(negedge clk); flush_in = 1'b0;
        check_eq("stf_suppressed", {29'd0, done, page_write, flag_we}, 32'd0);
        check_eq("stf_bus_done", {28'd0, mreq, iorq, rd, wr}, 32'd0);

        // Unflushed repeat raises page_write with done.
        @(negedge clk); present(3'd2, 16'h8000, 8'h3C);
        @(negedge clk); op_valid = 1'b0;
        check_eq("st_strobes", {28'd0, mreq, iorq, rd, wr}, 32'b1001);
        @(negedge clk);
        check_eq("st_done", {28'd0, done, page_write, flag_we, result_sel}, 32'b1100);
        check_eq("st_rdata_kept", {24'd0, rdata_out}, 32'h00);
        check_eq("st_flags", {24'd0, flag_out}, 32'h42);

        // OUT with bus_wait stuck high: timeout after 15 wait cycles.
        @(negedge clk); present(3'd4, 16'h00FE, 8'hC3); bus_wait = 1'b1;
        cnt = 0; seen = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk); op_valid = 1'b0;
            if (iorq && wr && stall && !bus_err) cnt = cnt + 1;
            if (done) seen = seen + 1;
        end
        check_eq("out_wait_cycles", cnt, 32'd16);
        @(negedge clk);
        check_eq("out_abort", {26'd0, bus_err, iorq, wr, stall, done, page_write}, 32'b100000);
        @(negedge clk); bus_wait = 1'b0;
        check_eq("out_err_pulse", {31'd0, bus_err}, 32'd0);
        check_eq("out_no_done", seen + {31'd0, done}, 32'd0);

        // Back-to-back LD then ST held during the stall.
        @(negedge clk); present(3'd1, 16'h0100, 8'h00); bus_rdata = 8'hA5;
        @(negedge clk); present(3'd2, 16'h0200, 8'h99);
        check_eq("b2b_ld_access", {29'd0, mreq, rd, stall}, 32'b111);
        @(negedge clk);
        check_eq("b2b_ld_done", {29'd0, done, result_sel, stall}, 32'b111);
        check_eq("b2b_ld_rdata", {24'd0, rdata_out}, 32'hA5);
        @(negedge clk); op_valid = 1'b0;
        check_eq("b2b_st_access", {28'd0, mreq, iorq, rd, wr}, 32'b1001);
        check_eq("b2b_st_bus", {8'd0, bus_addr, bus_wdata}, 32'h020099);
        @(negedge clk);
        check_eq("b2b_st_done", {29'd0, done, page_write, result_sel}, 32'b110);
        check_eq("b2b_rdata_kept", {24'd0, rdata_out}, 32'hA5);
        @(negedge clk);
        check_eq("b2b_no_dup", {26'd0, mreq, iorq, rd, wr, stall, done}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_q, failures_q);
        $finish;
    end

endmodule
